// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC^history-indexed saturating counters, speculative
// history with mispredict repair, post-reset table clear. Optional GSHARE_BYPASS_EN.
module gshare_predictor #(
  parameter int WIDTH_PC   = 10,
  parameter int WIDTH_HIST = 10,
  parameter int CTR_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           pc,
  input  logic                  pred_req,
  output logic                  pred_taken,
  output logic [WIDTH_HIST-1:0] pred_hist,
  output logic                  busy,
  input  logic                  upd_valid,
  input  logic [31:0]           upd_pc,
  input  logic [WIDTH_HIST-1:0] upd_hist,
  input  logic                  upd_taken,
  input  logic                  upd_mispred
);

  localparam int DEPTH = 1 << WIDTH_PC;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic [CTR_BITS-1:0]   ctr_mem [DEPTH];
  logic [0:0]            state_reg;
  logic [WIDTH_PC-1:0]   clr_ptr_reg;
  logic [WIDTH_HIST-1:0] spec_hist_reg;
  logic [WIDTH_HIST-1:0] spec_hist_next;
  logic [WIDTH_HIST-1:0] repair_hist;
  logic [WIDTH_HIST-1:0] shift_hist;
  logic [WIDTH_PC-1:0]   idx;
  logic [WIDTH_PC-1:0]   uidx;
  logic [CTR_BITS-1:0]   rd_ctr;
  logic [CTR_BITS-1:0]   upd_ctr;
  logic [CTR_BITS-1:0]   upd_ctr_next;
  logic                  ready;
  logic                  lookup_taken;
  logic                  wr_en;
  logic [WIDTH_PC-1:0]   wr_addr;
  logic [CTR_BITS-1:0]   wr_data;
  logic                  unused_pc_bits;

  assign ready = (state_reg == READY);
  assign busy  = ~ready;

  assign idx    = pc[WIDTH_PC+1:2] ^ WIDTH_PC'(spec_hist_reg);
  assign uidx   = upd_pc[WIDTH_PC+1:2] ^ WIDTH_PC'(upd_hist);
  assign rd_ctr = ctr_mem[idx];
  assign upd_ctr = ctr_mem[uidx];

  assign unused_pc_bits = ^{pc[31:WIDTH_PC+2], pc[1:0], upd_pc[31:WIDTH_PC+2], upd_pc[1:0]};

  always_comb begin
    upd_ctr_next = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != CTR_MAX) upd_ctr_next = upd_ctr + 1'b1;
    end else begin
      if (upd_ctr != '0) upd_ctr_next = upd_ctr - 1'b1;
    end
  end

`ifdef GSHARE_BYPASS_EN
  // Forward the counter being written this cycle when it is the one being read.
  assign lookup_taken = (upd_valid && (uidx == idx)) ? upd_ctr_next[CTR_BITS-1]
                                                     : rd_ctr[CTR_BITS-1];
`else
  assign lookup_taken = rd_ctr[CTR_BITS-1];
`endif

  assign pred_taken = ready & lookup_taken;
  assign pred_hist  = ready ? spec_hist_reg : '0;

  generate
    if (WIDTH_HIST == 1) begin : g_hist1
      assign repair_hist = upd_taken;
      assign shift_hist  = pred_taken;
    end else begin : g_histn
      assign repair_hist = {upd_hist[WIDTH_HIST-2:0], upd_taken};
      assign shift_hist  = {spec_hist_reg[WIDTH_HIST-2:0], pred_taken};
    end
  endgenerate

  // Repair wins over a same-cycle speculative advance.
  always_comb begin
    spec_hist_next = spec_hist_reg;
    if (upd_valid && upd_mispred) spec_hist_next = repair_hist;
    else if (pred_req)            spec_hist_next = shift_hist;
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = uidx;
    wr_data = upd_ctr_next;
    if (!reset) begin
      if (!ready) begin
        wr_en   = 1'b1;
        wr_addr = clr_ptr_reg;
        wr_data = CTR_INIT;
      end else if (upd_valid) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ctr_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= CLEAR;
      clr_ptr_reg   <= '0;
      spec_hist_reg <= '0;
    end else if (!ready) begin
      clr_ptr_reg <= clr_ptr_reg + 1'b1;
      if (&clr_ptr_reg) state_reg <= READY;
    end else begin
      spec_hist_reg <= spec_hist_next;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor (WIDTH_PC=4, WIDTH_HIST=2, CTR_BITS=2)
// against an array-based reference model; honours GSHARE_BYPASS_EN.
module tb_gshare_predictor;
  localparam int WPC = 4;
  localparam int WH = 2;
  localparam int CB = 2;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   pc;
  logic          pred_req;
  logic          pred_taken;
  logic [WH-1:0] pred_hist;
  logic          busy;
  logic          upd_valid;
  logic [31:0]   upd_pc;
  logic [WH-1:0] upd_hist;
  logic          upd_taken;
  logic          upd_mispred;

  always #5 clk = ~clk;

  gshare_predictor #(.WIDTH_PC(WPC), .WIDTH_HIST(WH), .CTR_BITS(CB)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pred_req(pred_req),
    .pred_taken(pred_taken), .pred_hist(pred_hist), .busy(busy),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_hist(upd_hist),
    .upd_taken(upd_taken), .upd_mispred(upd_mispred)
  );

  typedef struct {
    bit chk;
    bit busy;
    bit taken;
    int hist;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model state
  int m_ctr[DEPTH];
  int m_hist = 0;
  int m_clear_left = 0;
  bit m_known = 0;

  function automatic int sat(input int v);
    return (v < 0) ? 0 : ((v > 3) ? 3 : v);
  endfunction

  task automatic step(input bit r, input int p, input bit rq, input bit uv,
                      input int up, input int uh, input bit ut, input bit um);
    exp_t e;
    int   idx, uidx, nv;
    @(posedge clk);
    #1;
    reset = r; pc = 32'(p); pred_req = rq; upd_valid = uv;
    upd_pc = 32'(up); upd_hist = WH'(uh); upd_taken = ut; upd_mispred = um;
    e.chk = m_known;
    e.cyc = cyc;
    uidx = ((up / 4) % DEPTH) ^ uh;
    nv   = sat(m_ctr[uidx] + (ut ? 1 : -1));
    if (m_clear_left > 0) begin
      e.busy = 1; e.taken = 0; e.hist = 0;
    end else begin
      idx = ((p / 4) % DEPTH) ^ m_hist;
      e.busy  = 0;
      e.taken = (m_ctr[idx] >= 2);
`ifdef GSHARE_BYPASS_EN
      if (uv && uidx == idx) e.taken = (nv >= 2);
`endif
      e.hist = m_hist;
    end
    exp_q.push_back(e);
    if (r) begin
      m_known = 1; m_clear_left = DEPTH; m_hist = 0;
    end else if (m_clear_left > 0) begin
      m_ctr[DEPTH - m_clear_left] = 1;
      m_clear_left--;
    end else begin
      if (uv) m_ctr[uidx] = nv;
      if (uv && um)   m_hist = ((uh * 2) + int'(ut)) % 4;
      else if (rq)    m_hist = ((m_hist * 2) + int'(e.taken)) % 4;
    end
    cyc++;
  endtask

  task automatic idle(input int p);
    step(0, p, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset_sweep();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++)
      step(0, $urandom_range(0, 255), 1, 1, $urandom_range(0, 255), 1, 1, 1);
    for (int i = 0; i < DEPTH; i++) idle(i * 4);
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.chk) begin
        $display("txn cyc=%0d busy=%0b taken=%0b hist=%0d", mon_e.cyc, busy, pred_taken, pred_hist);
        checks++;
        if (busy !== mon_e.busy) begin
          errors++;
          $display("FAIL busy cyc=%0d got=%0b exp=%0b", mon_e.cyc, busy, mon_e.busy);
        end
        checks++;
        if (pred_taken !== mon_e.taken) begin
          errors++;
          $display("FAIL pred_taken cyc=%0d got=%0b exp=%0b", mon_e.cyc, pred_taken, mon_e.taken);
        end
        checks++;
        if (int'(pred_hist) != mon_e.hist || $isunknown(pred_hist)) begin
          errors++;
          $display("FAIL pred_hist cyc=%0d got=%0d exp=%0d", mon_e.cyc, pred_hist, mon_e.hist);
        end
      end
    end
  end

  initial begin
    reset = 0; pc = 0; pred_req = 0; upd_valid = 0; upd_pc = 0;
    upd_hist = 0; upd_taken = 0; upd_mispred = 0;

    // Reset and full sweep, updates during CLEAR are ignored
    do_reset_sweep();

    // Saturation at pc=0x40 (idx 0)
    repeat (3) step(0, 'h40, 0, 1, 'h40, 0, 1, 0);
    idle('h40);
    repeat (4) step(0, 'h40, 0, 1, 'h40, 0, 0, 0);
    idle('h40);

    // Speculative shift: entries 0 and 1 to strongly taken, then predict twice
    repeat (3) step(0, 'h40, 0, 1, 'h40, 0, 1, 0);
    repeat (3) step(0, 'h40, 0, 1, 'h44, 0, 1, 0);
    step(0, 'h40, 1, 0, 0, 0, 0, 0);
    step(0, 'h40, 1, 0, 0, 0, 0, 0);
    idle('h40);

    // Repair priority over same-cycle pred_req
    step(0, 'h40, 1, 1, 'h80, 2, 0, 1);
    idle('h40);

    // Snapshot indexing
    do_reset_sweep();
    step(0, 0, 0, 1, 'h0, 0, 1, 1);
    step(0, 'h4, 1, 0, 0, 0, 0, 0);
    step(0, 'h4, 0, 1, 'h4, 1, 1, 0);
    idle('h8);
    idle('h4);

    // Mid-sweep reset with update pulses during CLEAR
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, i * 4, 1, i % 2, 'h4, 1, 1, 1);
    step(1, 0, 0, 1, 'h4, 0, 1, 1);
    for (int i = 0; i < DEPTH + 2; i++) step(0, i * 4, 1, i % 2, 'h8, 2, 1, 1);
    for (int i = 0; i < DEPTH; i++) idle(i * 4);

    // Same-cycle read/write of one entry
    do_reset_sweep();
    step(0, 'h4, 0, 1, 'h4, 0, 1, 0);
    idle('h4);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit uv, r;
      r  = ($urandom_range(0, 299) == 0);
      uv = $urandom_range(0, 1) == 1;
      step(r, $urandom_range(0, 255), $urandom_range(0, 1) == 1, uv,
           $urandom_range(0, 255), $urandom_range(0, 3),
           $urandom_range(0, 1) == 1, uv && ($urandom_range(0, 3) == 0));
    end

    idle(0);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
Name: gshare_predictor

Overview:
- Next-generation global-history direction predictor for the fetch stage.
- Counter table is indexed by PC XOR speculative global history (gshare), with parametrised counter width.
- Each prediction emits the history snapshot it used; the snapshot travels down the pipeline and returns with the resolved branch, so the counter that made the prediction is the one updated.
- Adds a speculative history with misprediction repair, and a post-reset table-clear sweep.

Parameters:
- WIDTH_PC, 10, PC bits used for the index (pc[WIDTH_PC+1:2]); table depth = 2**WIDTH_PC.
- WIDTH_HIST, 10, global history length; must satisfy 1 <= WIDTH_HIST <= WIDTH_PC.
- CTR_BITS, 2, saturating counter width; must be >= 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pc  in  32  fetch address to predict.
- pred_req  in  1  fetch consumes the prediction this cycle; speculative history advances.
- pred_taken  out  1  predicted direction for pc.
- pred_hist  out  WIDTH_HIST  history snapshot used for this prediction.
- busy  out  1  table clear in progress; no predictions are valid.
- upd_valid  in  1  resolved-branch update strobe.
- upd_pc  in  32  PC of the resolved branch.
- upd_hist  in  WIDTH_HIST  pred_hist captured when that branch was predicted.
- upd_taken  in  1  actual direction.
- upd_mispred  in  1  direction was mispredicted; repair history. Ignored unless upd_valid.

Behaviour:
- Index, prediction side: idx = pc[WIDTH_PC+1:2] ^ {zeros, spec_hist}.
- Index, update side: uidx = upd_pc[WIDTH_PC+1:2] ^ {zeros, upd_hist}.
- pred_taken = MSB of counter[idx]. Combinational, same cycle as pc.
- pred_hist = spec_hist.
- FSM states are CLEAR and READY.
- Reset:
  - Synchronous reset, from any state, enters CLEAR with clr_ptr = 0 and spec_hist = 0.
  - A reset mid-sweep restarts the sweep from 0.
- CLEAR:
  - Each cycle writes counter[clr_ptr] = 2**(CTR_BITS-1)-1 (weakly not-taken; 01 for CTR_BITS=2), then clr_ptr++.
  - After writing entry 2**WIDTH_PC-1, moves to READY on the next edge.
  - busy = 1, pred_taken = 0, pred_hist = 0 throughout.
  - pred_req and upd_valid are ignored; the update is dropped and history is not touched.
  - Total sweep: 2**WIDTH_PC cycles after reset deasserts.
- READY:
  - busy = 0.
  - Counter update on upd_valid: counter[uidx] +1 if upd_taken, -1 if not.
  - Counter saturates at all-ones and at 0; no wrap.
  - The write is visible to reads in the following cycle.
- Speculative history, evaluated at each edge in READY:
  - upd_valid & upd_mispred: spec_hist <= {upd_hist[WIDTH_HIST-2:0], upd_taken}. Repair has priority; a same-cycle pred_req is discarded.
  - else pred_req: spec_hist <= {spec_hist[WIDTH_HIST-2:0], pred_taken}.
  - else hold.
  - WIDTH_HIST = 1: the new value is just the shifted-in bit.
- Same-cycle read and write of one entry: the read returns the old value (unless GSHARE_BYPASS_EN is defined).
- Updates without upd_mispred change only the counter, never spec_hist.

Optional Feature:
- Macro: GSHARE_BYPASS_EN.
- Defined: when upd_valid and uidx == idx in READY, pred_taken uses the MSB of the counter value being written this cycle (post-saturation).
- Undefined: no forwarding; pred_taken uses the stored value.

Test Plan (WIDTH_PC=4, WIDTH_HIST=2, CTR_BITS=2 unless noted):
- Reset: reset high 1 cycle, then low -> busy=1 for exactly 16 cycles, then 0; all 16 entries read 01; pred_taken=0 for every pc.
- Saturation: pc=0x40, hist 00, three updates upd_taken=1 with upd_hist=00 -> counter 01→10→11→11, pred_taken=1. Then four not-taken -> counter 00, pred_taken=0.
- Speculative shift: pred_req=1 for 2 cycles with pred_taken=1 -> spec_hist 00→01→11; pred_hist follows.
- Repair priority: spec_hist=11, same cycle upd_valid=1, upd_mispred=1, upd_hist=10, upd_taken=0, pred_req=1 -> next spec_hist=00.
- Snapshot indexing: predict pc=0x4 with hist=01 (idx 0), then advance history to 10, then update upd_pc=0x4, upd_hist=01, taken -> only entry 0 changes; entry 3 is unchanged.
- Mid-sweep reset: reset during cycle 5 of CLEAR, plus upd_valid pulses during CLEAR -> sweep restarts; busy lasts 16 more cycles; counters all 01.
- GSHARE_BYPASS_EN defined: entry idx=01 at 01, same-cycle taken update to the same idx -> pred_taken=1 that cycle. Undefined: pred_taken=0 that cycle.
